// File: rtl/bit_serializer_if.sv
// Parallel-word and serial-bit handshake bundle for bit_serializer.
// The master side drives words and bit_ready, and the slave side is the serializer.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             flush;
    logic             bit_ready;
    logic             serial_bit;
    logic             bit_valid;
    logic             frame_start;
    logic             frame_last;

    modport master (
        output data_in,
        output data_valid,
        output flush,
        output bit_ready,
        input  data_ready,
        input  serial_bit,
        input  bit_valid,
        input  frame_start,
        input  frame_last
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  flush,
        input  bit_ready,
        output data_ready,
        output serial_bit,
        output bit_valid,
        output frame_start,
        output frame_last
    );
endinterface

// File: rtl/bit_serializer.sv
// MSB-first word-to-bit serializer with ready/valid on both sides and a synchronous flush.
// Every output comes straight from a register, so inputs never reach serial_bit or bit_valid combinationally.
module bit_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clock,
    input logic              reset,
    bit_serializer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               ready_q;
    logic               valid_q;
    logic               start_q;
    logic               last_q;
    logic               accept;
    logic               transfer;

    always_comb begin
        accept   = 1'b0;
        transfer = 1'b0;
        accept   = (state == IDLE) && ready_q && bus.data_valid;
        transfer = valid_q && bus.bit_ready;
    end

    // frame_start/frame_last are registered copies of (cnt == WIDTH) and
    // (cnt == 1). They are computed from the counter's next value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (bus.flush) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        state   <= SHIFT;
                        shreg   <= bus.data_in;
                        cnt     <= CNT_W'(WIDTH);
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                        start_q <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (transfer) begin
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        cnt     <= cnt - CNT_W'(1);
                        start_q <= 1'b0;
                        last_q  <= (cnt == CNT_W'(2));
                        if (last_q) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_ready  = ready_q;
    assign bus.serial_bit  = shreg[WIDTH-1];
    assign bus.bit_valid   = valid_q;
    assign bus.frame_start = start_q;
    assign bus.frame_last  = last_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: vector table, handcrafted corner sequences,
// a mod-5 stream check and randomized traffic against a queue-based reference model.
module tb_bit_serializer;
    localparam int unsigned WIDTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bit_serializer_if #(.WIDTH(WIDTH)) bus ();

    bit_serializer #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // order: data_valid, data_in, bit_ready, flush | ready, valid, bit, start, last
    typedef struct packed {
        logic             dv;
        logic [WIDTH-1:0] din;
        logic             br;
        logic             fsh;
        logic             rdy;
        logic             bv;
        logic             sb;
        logic             fs;
        logic             lst;
    } vec_t;

    function automatic logic [4:0] outs();
        return {bus.data_ready, bus.bit_valid, bus.serial_bit, bus.frame_start, bus.frame_last};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic dv, input logic [WIDTH-1:0] din, input logic br, input logic fsh);
        bus.data_valid = dv;
        bus.data_in    = din;
        bus.bit_ready  = br;
        bus.flush      = fsh;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t             vecs[$];
        bit               model_q[$];
        logic             model_rdy;
        logic             r_dv, r_br, r_fl;
        logic [WIDTH-1:0] r_din;
        logic [4:0]       exp_o;
        int               rem;

        drive(1'b0, '0, 1'b0, 1'b0);

        // Reset state, both before and across clock edges
        #2;
        check("reset_state", outs(), 5'b00000);
        step();
        step();
        check("reset_held", outs(), 5'b00000);
        #3 reset = 1'b1;

        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        // 8'd7 with bit_ready high: 0,0,0,0,0,1,1,1 then ready
        vecs.push_back('{1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        // 8'hA5 with a 3-cycle stall after bit 2; 8'h80 offered mid-frame must be ignored
        vecs.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].dv, vecs[i].din, vecs[i].br, vecs[i].fsh);
            step();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].rdy, vecs[i].bv, vecs[i].sb, vecs[i].fs, vecs[i].lst});
        end

        // Flush during bit 3 of 8'hFF, flush beating an accept, then 8'h01
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        step();
        check("ff_bit1", outs(), 5'b01110);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        step();
        check("ff_bit3", outs(), 5'b01100);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        step();
        check("flush_idle", outs(), 5'b10000);
        drive(1'b1, 8'h55, 1'b1, 1'b1);
        step();
        check("flush_over_accept", outs(), 5'b10000);
        drive(1'b1, 8'h01, 1'b1, 1'b0);
        step();
        check("w01_bit1", outs(), 5'b01010);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 2; k <= 8; k++) begin
            step();
            check($sformatf("w01_bit%0d", k), outs(), {1'b0, 1'b1, k == 8, 1'b0, k == 8});
        end
        step();
        check("w01_done", outs(), 5'b10000);

        // Asynchronous reset while bit 4 of 8'hF0 is presented
        drive(1'b1, 8'hF0, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        step();
        step();
        check("f0_bit4", outs(), 5'b01100);
        #3 reset = 1'b0;
        #1 check("async_reset", outs(), 5'b00000);
        #2 reset = 1'b1;
        step();
        check("post_reset_ready", outs(), 5'b10000);
        for (int k = 0; k < 10; k++) begin
            step();
            check("no_residual", outs(), 5'b10000);
        end

        // Back-to-back words 0..254, recomputing x mod 5 from the serial stream
        rem = 0;
        for (int x = 0; x < 255; x++) begin
            drive(1'b1, WIDTH'(x), 1'b1, 1'b0);
            check("m5_ready", {31'd0, bus.data_ready}, 32'd1);
            step();
            for (int b = 0; b < 8; b++) begin
                check("m5_frame", {bus.bit_valid, bus.data_ready, bus.frame_start, bus.frame_last},
                      {1'b1, 1'b0, b == 0, b == 7});
                if (bus.frame_start) rem = 0;
                rem = (rem * 2 + int'(bus.serial_bit)) % 5;
                if (b == 7) check($sformatf("m5_rem_%0d", x), rem, x % 5);
                step();
            end
        end

        // Randomized traffic against a bit-queue reference model
        model_q.delete();
        model_rdy = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            r_dv  = 1'($urandom_range(0, 1));
            r_din = WIDTH'($urandom);
            r_br  = ($urandom_range(0, 3) != 0);
            r_fl  = ($urandom_range(0, 15) == 0);
            drive(r_dv, r_din, r_br, r_fl);
            if (r_fl) begin
                model_q.delete();
            end else if (model_q.size() == 0) begin
                if (model_rdy && r_dv)
                    for (int i = WIDTH - 1; i >= 0; i--) model_q.push_back(r_din[i]);
            end else if (r_br) begin
                void'(model_q.pop_front());
            end
            model_rdy = (model_q.size() == 0);
            step();
            exp_o = {model_rdy, model_q.size() > 0,
                     (model_q.size() > 0) ? model_q[0] : 1'b0,
                     model_q.size() == WIDTH, model_q.size() == 1};
            check($sformatf("rand%0d", cyc), outs(), exp_o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
